// File: rtl/mode_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mode_arbiter
//  Description : Owns the watch/stopwatch mode select. A synchronized slide
//                switch (and optionally a UART 'M'/'m' byte) requests mode
//                changes. Every committed change is followed by a button
//                blanking window. Debounced button pulses are routed, one
//                clock later, only to the core that owns the current mode.
//  Options     : MODE_ARBITER_UART_EN - when defined, the UART toggle path is
//                built; otherwise the UART ports are accepted but unused.
//  Revision    : 1.0 - initial release
// ============================================================================
module mode_arbiter #(
   parameter int BLANK_CYCLES = 1_000_000   // blanking window length in clocks, >= 1
) (
   input  logic       clk,               // system clock, rising edge
   input  logic       rst,               // asynchronous reset, active low
   input  logic       sw_mode,           // raw slide switch, asynchronous
   input  logic       uart_rx_done,      // one-cycle strobe, byte valid
   input  logic [7:0] uart_rx_data,      // received byte
   input  logic       btnU,              // debounced one-cycle pulses
   input  logic       btnD,
   input  logic       btnL,
   input  logic       btnR,
   output logic       mode1,             // 1 = stopwatch, 0 = watch
   output logic       mode_changed,      // pulse on each committed change
   output logic       blanking,          // high while buttons are forced low
   output logic       o_watch_btnU,
   output logic       o_watch_btnD,
   output logic       o_watch_btnL,
   output logic       o_watch_btnR,
   output logic       o_stopwatch_btnL,
   output logic       o_stopwatch_btnR
);

   // Counter width: at least one bit, enough to hold BLANK_CYCLES-1.
   localparam int                 c_cnt_w    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_WATCH     = 2'd0,
      ST_BLANK_SW  = 2'd1,
      ST_STOPWATCH = 2'd2,
      ST_BLANK_W   = 2'd3
   } state_t;

   // Registered state
   state_t              state_q,  state_d;
   logic [c_cnt_w-1:0]  cnt_q,    cnt_d;
   logic                sync1_q,  sync1_d;
   logic                sync2_q,  sync2_d;
   logic                sw_prev_q, sw_prev_d;
   logic                mode1_q,  mode1_d;
   logic                mode_changed_q, mode_changed_d;
   logic                blanking_q, blanking_d;
   logic                watch_u_q, watch_u_d;
   logic                watch_d_q, watch_d_d;
   logic                watch_l_q, watch_l_d;
   logic                watch_r_q, watch_r_d;
   logic                stop_l_q,  stop_l_d;
   logic                stop_r_q,  stop_r_d;

   // Request decode
   logic w_sw_rise;
   logic w_sw_fall;
   logic w_uart_toggle;
   logic w_req_stopwatch;
   logic w_req_watch;
   logic w_blank_now;
   logic w_blank_next;

   assign w_sw_rise =  sync2_q & ~sw_prev_q;
   assign w_sw_fall = ~sync2_q &  sw_prev_q;

`ifdef MODE_ARBITER_UART_EN
   assign w_uart_toggle = uart_rx_done &&
                          ((uart_rx_data == 8'h4D) || (uart_rx_data == 8'h6D));
`else
   // UART ports are kept for pin compatibility but carry no function here.
   logic w_uart_unused;
   assign w_uart_unused = uart_rx_done ^ (^uart_rx_data);
   assign w_uart_toggle = 1'b0;
`endif

   // Any switch edge takes priority over a UART toggle in the same cycle; an
   // edge that asks for the mode already held therefore blocks the UART too.
   assign w_req_stopwatch = w_sw_rise | (~w_sw_fall & w_uart_toggle);
   assign w_req_watch     = w_sw_fall | (~w_sw_rise & w_uart_toggle);

   assign w_blank_now  = (state_q == ST_BLANK_SW) || (state_q == ST_BLANK_W);

   // Next-state, counter, synchronizer and registered output computation
   always_comb begin
      sync1_d   = sw_mode;
      sync2_d   = sync1_q;
      sw_prev_d = sync2_q;
      state_d   = state_q;
      cnt_d     = cnt_q;

      unique case (state_q)
         ST_WATCH: begin
            if (w_req_stopwatch) begin
               state_d = ST_BLANK_SW;
               cnt_d   = '0;
            end
         end
         ST_STOPWATCH: begin
            if (w_req_watch) begin
               state_d = ST_BLANK_W;
               cnt_d   = '0;
            end
         end
         ST_BLANK_SW: begin
            if (cnt_q == c_cnt_last) begin
               state_d = ST_STOPWATCH;
            end else begin
               cnt_d = cnt_q + c_cnt_w'(1);
            end
         end
         ST_BLANK_W: begin
            if (cnt_q == c_cnt_last) begin
               state_d = ST_WATCH;
            end else begin
               cnt_d = cnt_q + c_cnt_w'(1);
            end
         end
         default: begin
            state_d = ST_WATCH;
            cnt_d   = '0;
         end
      endcase

      // Status outputs are registered alongside the state so they line up
      // with it exactly.
      w_blank_next   = (state_d == ST_BLANK_SW) || (state_d == ST_BLANK_W);
      mode1_d        = (state_d == ST_BLANK_SW) || (state_d == ST_STOPWATCH);
      blanking_d     = w_blank_next;
      mode_changed_d = w_blank_next & ~w_blank_now;

      // Buttons follow the owner of the current cycle, so a pulse coincident
      // with a mode request still reaches the outgoing owner.
      watch_u_d = 1'b0;
      watch_d_d = 1'b0;
      watch_l_d = 1'b0;
      watch_r_d = 1'b0;
      stop_l_d  = 1'b0;
      stop_r_d  = 1'b0;
      if (state_q == ST_WATCH) begin
         watch_u_d = btnU;
         watch_d_d = btnD;
         watch_l_d = btnL;
         watch_r_d = btnR;
      end else if (state_q == ST_STOPWATCH) begin
         stop_l_d  = btnL;
         stop_r_d  = btnR;
      end
   end

   // State, counter, synchronizer and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_WATCH;
         cnt_q          <= '0;
         sync1_q        <= 1'b0;
         sync2_q        <= 1'b0;
         sw_prev_q      <= 1'b0;
         mode1_q        <= 1'b0;
         mode_changed_q <= 1'b0;
         blanking_q     <= 1'b0;
         watch_u_q      <= 1'b0;
         watch_d_q      <= 1'b0;
         watch_l_q      <= 1'b0;
         watch_r_q      <= 1'b0;
         stop_l_q       <= 1'b0;
         stop_r_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         sync1_q        <= sync1_d;
         sync2_q        <= sync2_d;
         sw_prev_q      <= sw_prev_d;
         mode1_q        <= mode1_d;
         mode_changed_q <= mode_changed_d;
         blanking_q     <= blanking_d;
         watch_u_q      <= watch_u_d;
         watch_d_q      <= watch_d_d;
         watch_l_q      <= watch_l_d;
         watch_r_q      <= watch_r_d;
         stop_l_q       <= stop_l_d;
         stop_r_q       <= stop_r_d;
      end
   end

   assign mode1            = mode1_q;
   assign mode_changed     = mode_changed_q;
   assign blanking         = blanking_q;
   assign o_watch_btnU     = watch_u_q;
   assign o_watch_btnD     = watch_d_q;
   assign o_watch_btnL     = watch_l_q;
   assign o_watch_btnR     = watch_r_q;
   assign o_stopwatch_btnL = stop_l_q;
   assign o_stopwatch_btnR = stop_r_q;

endmodule
`default_nettype wire
